dm_cache_responder: RTL and testbench

//  Responder end of the CPU<->cache request interface: accepts read/write/Address/Write_Data,

---
 rtl/dm_cache_responder.sv | 198 +++++++++++++++++++
 tb/tb_dm_cache_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_responder.sv
// Direct-mapped, write-back, write-allocate cache sitting between a CPU
// requester and a block-oriented main memory. Lookups are combinational in
// IDLE; misses optionally write back the victim line, then fetch the block.
module dm_cache_responder #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_LINES      = 4,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDR_W-1:0]                Address,
  input  logic [DATA_W-1:0]                Write_Data,
  output logic [DATA_W-1:0]                rData,
  output logic                             hit,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                             mem_ready,
  output logic [7:0]                       hit_cnt,
  output logic [7:0]                       miss_cnt
);

  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned TagW  = ADDR_W - 4 - IdxW;
  localparam int unsigned LineW = DATA_W * WORDS_PER_LINE;

  typedef enum logic [1:0] {StIdle, StWb, StAlloc} state_e;

  state_e                  state_q, state_d;
  logic [LineW-1:0]        line_q [NUM_LINES];
  logic [LineW-1:0]        line_d [NUM_LINES];
  logic [TagW-1:0]         tag_q  [NUM_LINES];
  logic [TagW-1:0]         tag_d  [NUM_LINES];
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic [NUM_LINES-1:0]    dirty_q, dirty_d;
  logic [7:0]              hit_cnt_q, hit_cnt_d;
  logic [7:0]              miss_cnt_q, miss_cnt_d;
  // Set when the current request has missed, so its retry hit is not counted.
  logic                    retry_q, retry_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [LineW-1:0]        mem_wdata_q, mem_wdata_d;

  logic [IdxW-1:0]         idx;
  logic [TagW-1:0]         req_tag;
  logic [1:0]              wsel;
  int unsigned             word_off;
  logic                    req;
  logic                    match;
  logic                    unused_addr;

  assign idx         = Address[4 +: IdxW];
  assign req_tag     = Address[ADDR_W-1 -: TagW];
  assign wsel        = Address[3:2];
  assign word_off    = 32'(wsel) * DATA_W;
  assign req         = read | write;
  assign match       = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_addr = ^Address[1:0];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: miss goes to writeback if the victim is dirty, else to fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req && !match) begin
          state_d = dirty_q[idx] ? StWb : StAlloc;
        end
      end
      StWb: begin
        if (mem_ready) state_d = StAlloc;
      end
      StAlloc: begin
        if (mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: combinational hit/rData, registered memory-side request from next state.
  always_comb begin
    hit         = (state_q == StIdle) && req && match;
    rData       = '0;
    if (hit && read && !write) begin
      rData = line_q[idx][word_off +: DATA_W];
    end
    mem_read_d  = (state_d == StAlloc);
    mem_write_d = (state_d == StWb);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      StWb: begin
        mem_addr_d  = {tag_q[idx], idx, 4'b0000};
        mem_wdata_d = line_q[idx];
      end
      StAlloc: begin
        mem_addr_d  = {Address[ADDR_W-1:4], 4'b0000};
      end
      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // Datapath next-state: array updates, line status and counters.
  always_comb begin
    line_d     = line_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    retry_d    = retry_q;

    if (hit) begin
      retry_d = 1'b0;
      if (!retry_q && (hit_cnt_q != 8'hFF)) begin
        hit_cnt_d = hit_cnt_q + 8'd1;
      end
      if (write) begin
        line_d[idx][word_off +: DATA_W] = Write_Data;
        dirty_d[idx]                    = 1'b1;
      end
    end

    if ((state_q == StIdle) && req && !match) begin
      retry_d = 1'b1;
      if (miss_cnt_q != 8'hFF) begin
        miss_cnt_d = miss_cnt_q + 8'd1;
      end
    end

    if ((state_q == StWb) && mem_ready) begin
      dirty_d[idx] = 1'b0;
    end

    if ((state_q == StAlloc) && mem_ready) begin
      line_d[idx]  = mem_rdata;
      tag_d[idx]   = req_tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
  end

  // Control and status flops with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      retry_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      retry_q     <= retry_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Data and tag storage; contents are qualified by valid, so no reset needed.
  always_ff @(posedge clock) begin
    line_q <= line_d;
    tag_q  <= tag_d;
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_responder.sv
// Bench for dm_cache_responder: a flat word-level memory image is the golden
// view (the cache must be transparent), plus a residency model for hit/miss,
// writeback and latency expectations, and a block memory serving transfers.
module tb_dm_cache_responder;

  logic         clock;
  logic         reset;
  logic         read;
  logic         write;
  logic [7:0]   Address;
  logic [31:0]  Write_Data;
  logic [31:0]  rData;
  logic         hit;
  logic         mem_read;
  logic         mem_write;
  logic [7:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [7:0]   hit_cnt;
  logic [7:0]   miss_cnt;

  int errors = 0;
  int checks = 0;

  // Environment memory (16 blocks of 4 words) and golden word image.
  logic [127:0] mem_blk [16];
  logic [31:0]  gold    [64];
  // Residency model: which block each line holds and whether it is modified.
  logic         m_valid [4];
  logic [1:0]   m_tag   [4];
  logic         m_dirty [4];
  int           hit_e;
  int           miss_e;

  dm_cache_responder dut (
    .clock      (clock),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .Address    (Address),
    .Write_Data (Write_Data),
    .rData      (rData),
    .hit        (hit),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Everything the cache held is lost on reset; memory becomes the truth again.
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 2'd0;
    end
    for (int b = 0; b < 16; b++) begin
      for (int w = 0; w < 4; w++) gold[b*4+w] = mem_blk[b][w*32 +: 32];
    end
    hit_e  = 0;
    miss_e = 0;
  endtask

  function automatic logic [127:0] gold_block(input int b);
    return {gold[b*4+3], gold[b*4+2], gold[b*4+1], gold[b*4]};
  endfunction

  // One CPU request held until hit; memory answers d_wb / d_al cycles after request seen.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input int d_wb, input int d_al);
    int       l;
    int       wi;
    int       lat;
    int       wb_k;
    int       al_k;
    int       exp_lat;
    logic     first;
    logic     exp_wb;
    logic     done;
    logic [7:0] victim;
    l       = int'(addr[5:4]);
    wi      = int'(addr[7:2]);
    first   = m_valid[l] && (m_tag[l] == addr[7:6]);
    exp_wb  = !first && m_valid[l] && m_dirty[l];
    victim  = {m_tag[l], addr[5:4], 4'h0};
    exp_lat = first ? 0 : (2 + d_al + (exp_wb ? d_wb + 1 : 0));
    @(negedge clock);
    read       = rd;
    write      = wr;
    Address    = addr;
    Write_Data = wd;
    mem_ready  = 1'b0;
    #1;
    done = 1'b0;
    lat  = -1;
    wb_k = 0;
    al_k = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (hit) begin
        done = 1'b1;
        lat  = cyc;
      end else begin
        chk("mem_rw_exclusive", {1'b0, mem_read & mem_write}, 0);
        if (mem_write) begin
          if (wb_k == 0) begin
            chk("wb_addr", mem_addr, victim);
            chk("wb_data", mem_wdata, gold_block(int'(victim[7:4])));
          end
          if (wb_k == d_wb) begin
            mem_ready = 1'b1;
            mem_blk[mem_addr[7:4]] = mem_wdata;
          end
          wb_k++;
        end else if (mem_read) begin
          if (al_k == 0) chk("alloc_addr", mem_addr, {addr[7:4], 4'h0});
          if (al_k == d_al) begin
            mem_ready = 1'b1;
            mem_rdata = mem_blk[mem_addr[7:4]];
          end
          al_k++;
        end
        @(negedge clock);
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
      end
    end
    chk("hit_seen", {1'b0, done}, 1);
    chk("latency", lat, exp_lat);
    chk("wb_seen", {1'b0, wb_k > 0}, {1'b0, exp_wb});
    chk("rdata", rData, (rd && !wr) ? gold[wi] : 32'd0);
    if (wr) gold[wi] = wd;
    if (first) begin
      if (hit_e < 255) hit_e++;
      m_dirty[l] = m_dirty[l] | wr;
    end else begin
      if (miss_e < 255) miss_e++;
      m_valid[l] = 1'b1;
      m_tag[l]   = addr[7:6];
      m_dirty[l] = wr;
    end
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
    chk("hit_cnt", hit_cnt, hit_e);
    chk("miss_cnt", miss_cnt, miss_e);
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    Address    = 8'h00;
    Write_Data = 32'h0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    for (int b = 0; b < 16; b++) mem_blk[b] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[6][64 +: 32] = 32'd841;
    model_reset();

    // Reset state.
    #3;
    chk("rst_hit", {1'b0, hit}, 0);
    chk("rst_rdata", rData, 0);
    chk("rst_mem_read", {1'b0, mem_read}, 0);
    chk("rst_mem_write", {1'b0, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(negedge clock);
    reset = 1'b1;

    // Cold read miss, then the same read hits with no memory traffic.
    do_req(1'b1, 1'b0, 8'h68, 32'h0, 0, 3);
    chk("t1_rdata_841", gold[26], 32'd841);
    do_req(1'b1, 1'b0, 8'h68, 32'h0, 0, 0);

    // Write-allocate, then a conflicting write forces writeback of 0x30.
    do_req(1'b0, 1'b1, 8'h34, 32'd676, 0, 1);
    do_req(1'b0, 1'b1, 8'hF4, 32'd280, 2, 1);
    do_req(1'b1, 1'b0, 8'hF4, 32'h0, 0, 0);
    do_req(1'b1, 1'b0, 8'h34, 32'h0, 1, 2);
    chk("t3_mem_word1", mem_blk[15][32 +: 32], 32'd280);

    // Reset in the middle of a fetch drops mem_read at once and abandons the fill.
    @(negedge clock);
    read    = 1'b1;
    Address = 8'h24;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t4_alloc_started", {1'b0, mem_read}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t4_mem_read_drop", {1'b0, mem_read}, 0);
    chk("t4_hit_cnt_clr", hit_cnt, 0);
    chk("t4_miss_cnt_clr", miss_cnt, 0);
    chk("t4_mem_addr_clr", mem_addr, 0);
    read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    do_req(1'b1, 1'b0, 8'h34, 32'h0, 0, 1);
    do_req(1'b1, 1'b0, 8'h24, 32'h0, 0, 0);

    // Read and write together on a resident line act as a write.
    do_req(1'b1, 1'b1, 8'h28, 32'hCAFE_0005, 0, 0);
    do_req(1'b1, 1'b0, 8'h28, 32'h0, 0, 0);
    do_req(1'b1, 1'b0, 8'hE8, 32'h0, 1, 0);
    do_req(1'b1, 1'b0, 8'h28, 32'h0, 0, 1);

    // Hit counter saturates; miss counter does not move.
    for (int i = 0; i < 300; i++) do_req(1'b1, 1'b0, 8'h28, 32'h0, 0, 0);
    chk("t6_hit_sat", hit_cnt, 255);

    // Randomised traffic from a clean reset.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      logic [1:0] op;
      a  = 8'($urandom) & 8'hFC;
      op = 2'($urandom_range(0, 3));
      do_req(op != 2'd1, op != 2'd0, a, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
